// File: rtl/matrix_operand_loader.sv
// ----------------------------------------------------------------------------
// matrix_operand_loader
//
// Front end of the matrix multiplier. Elements arrive one per handshake,
// row-major: all of A first, then all of B. Each element is shifted into a
// per-matrix assembly register. When the last B element is taken, the
// assembled pair moves into the output slot. The slot drives the flat operand
// buses a/b until downstream consumes it.
//
// There are two levels of storage: the assembly registers and the output slot.
// The next pair can therefore be assembled while the multiplier still holds
// the current one. A completed pair that finds the slot occupied waits in the
// assembly registers (PEND), and input is stalled until the slot frees up.
//
// Ports
//   clk        : single clock, all logic on the rising edge
//   rst        : synchronous active-high reset (priority over clr)
//   clr        : synchronous abort of the partial assembly; slot untouched
//   in_data    : next element (elemW bits)
//   in_valid   : in_data valid
//   in_ready   : loader takes in_data this cycle (combinational from state)
//   a, b       : packed A / B operands, zero above matrixALen / matrixBLen
//   out_valid  : a/b hold a complete pair
//   out_ready  : downstream consumes the pair this cycle
// ----------------------------------------------------------------------------
module matrix_operand_loader #(
    parameter int aRow       = 3,
    parameter int aCol       = 2,
    parameter int bRow       = 2,
    parameter int bCol       = 3,
    parameter int elemW      = 8,
    parameter int busW       = 128,
    parameter int matrixALen = aRow * aCol * elemW,
    parameter int matrixBLen = bRow * bCol * elemW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [elemW-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [busW-1:0]  a,
    output logic [busW-1:0]  b,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int NA   = aRow * aCol;
    localparam int NB   = bRow * bCol;
    localparam int MAXN = (NA > NB) ? NA : NB;
    localparam int IDXW = (MAXN > 1) ? $clog2(MAXN) : 1;

    typedef enum logic [1:0] {
        FILL_A = 2'd0,
        FILL_B = 2'd1,
        PEND   = 2'd2
    } state_t;

    state_t                  state_q,     state_d;
    logic [IDXW-1:0]         idx_q,       idx_d;
    logic [matrixALen-1:0]   asm_a_q,     asm_a_d;
    logic [matrixBLen-1:0]   asm_b_q,     asm_b_d;
    logic [busW-1:0]         a_q,         a_d;
    logic [busW-1:0]         b_q,         b_d;
    logic                    out_valid_q, out_valid_d;

    logic                    accept_s;
    logic                    slot_free_s;
    logic                    copy_s;

    // Ready depends only on reset and state, so upstream sees no combinational path from its own valid.
    assign in_ready    = !rst && (state_q != PEND);
    // An element is taken only when ready and not being aborted by clr.
    assign accept_s    = in_valid && in_ready && !clr;
    // The slot can take a new pair if it is empty or is being drained this cycle.
    assign slot_free_s = !out_valid_q || out_ready;

    assign a         = a_q;
    assign b         = b_q;
    assign out_valid = out_valid_q;

    // Next-state, element counter, assembly shift registers and output slot.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        asm_a_d     = asm_a_q;
        asm_b_d     = asm_b_q;
        a_d         = a_q;
        b_d         = b_q;
        out_valid_d = out_valid_q;
        copy_s      = 1'b0;

        if (clr) begin
            // Abort the partial (or pending) pair; the output slot is left alone.
            state_d = FILL_A;
            idx_d   = '0;
            asm_a_d = '0;
            asm_b_d = '0;
        end else begin
            case (state_q)
                FILL_A: begin
                    if (accept_s) begin
                        asm_a_d = (asm_a_q << elemW) | matrixALen'(in_data);
                        if (idx_q == IDXW'(NA - 1)) begin
                            idx_d   = '0;
                            state_d = FILL_B;
                        end else begin
                            idx_d = idx_q + IDXW'(1);
                        end
                    end else begin
                        idx_d = idx_q;
                    end
                end
                FILL_B: begin
                    if (accept_s) begin
                        asm_b_d = (asm_b_q << elemW) | matrixBLen'(in_data);
                        if (idx_q == IDXW'(NB - 1)) begin
                            idx_d = '0;
                            if (slot_free_s) begin
                                copy_s  = 1'b1;
                                state_d = FILL_A;
                            end else begin
                                state_d = PEND;
                            end
                        end else begin
                            idx_d = idx_q + IDXW'(1);
                        end
                    end else begin
                        idx_d = idx_q;
                    end
                end
                PEND: begin
                    if (slot_free_s) begin
                        copy_s  = 1'b1;
                        state_d = FILL_A;
                    end else begin
                        state_d = PEND;
                    end
                end
                default: begin
                    state_d = FILL_A;
                    idx_d   = '0;
                end
            endcase
        end

        // asm_b_d equals asm_b_q unless the final B element lands this cycle.
        // So a single expression covers both the direct and the pending copy.
        if (copy_s) begin
            a_d         = busW'(asm_a_q);
            b_d         = busW'(asm_b_d);
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State and data registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL_A;
            idx_q       <= '0;
            asm_a_q     <= '0;
            asm_b_q     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            asm_a_q     <= asm_a_d;
            asm_b_q     <= asm_b_d;
            a_q         <= a_d;
            b_q         <= b_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_matrix_operand_loader.sv
// ----------------------------------------------------------------------------
// Testbench for matrix_operand_loader (default parameters).
// The reference model keeps a queue of accepted elements, an optional pending
// pair and the output slot. Pairs are packed with plain arithmetic once twelve
// elements have been collected. Directed scenarios are followed by a
// randomized phase with rare clr and rst.
// ----------------------------------------------------------------------------
module tb_matrix_operand_loader;

    localparam int NA = 6;
    localparam int NB = 6;

    logic         clk;
    logic         rst;
    logic         clr;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] a;
    logic [127:0] b;
    logic         out_valid;
    logic         out_ready;

    int errors;
    int checks;

    // reference model state
    logic [7:0]   m_q[$];
    logic         m_pend;
    logic [127:0] m_pa, m_pb;
    logic         m_valid;
    logic [127:0] m_a, m_b;
    logic         model_live;

    logic [7:0] basic_seq [12] = '{8'd1, 8'd2, 8'd1, 8'd2, 8'd1, 8'd2,
                                   8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};

    matrix_operand_loader dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: elements collected into a queue; a full queue becomes a pair.
    initial begin
        logic acc;
        logic free;
        model_live = 1'b0;
        m_pend = 1'b0; m_valid = 1'b0; m_a = '0; m_b = '0; m_pa = '0; m_pb = '0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_q.delete();
                m_pend = 1'b0; m_valid = 1'b0; m_a = '0; m_b = '0;
                model_live = 1'b1;
            end else begin
                acc  = in_valid && !m_pend && !clr;
                free = !m_valid || out_ready;
                if (clr) begin
                    m_q.delete();
                    m_pend = 1'b0;
                    if (out_ready) m_valid = 1'b0;
                end else begin
                    if (acc) begin
                        m_q.push_back(in_data);
                        if (m_q.size() == NA + NB) begin
                            m_pa = '0;
                            m_pb = '0;
                            for (int i = 0; i < NA; i++) m_pa = m_pa * 256 + m_q[i];
                            for (int i = 0; i < NB; i++) m_pb = m_pb * 256 + m_q[NA + i];
                            m_q.delete();
                            m_pend = 1'b1;
                        end
                    end
                    if (m_pend && free) begin
                        m_a = m_pa; m_b = m_pb; m_valid = 1'b1; m_pend = 1'b0;
                    end else if (out_ready) begin
                        m_valid = 1'b0;
                    end
                end
            end
        end
    end

    // Compare every cycle on the falling edge once the model has seen reset.
    initial begin
        forever begin
            @(negedge clk);
            if (model_live) begin
                chk("cyc_in_ready", {127'd0, in_ready}, {127'd0, (!rst && !m_pend)});
                chk("cyc_out_valid", {127'd0, out_valid}, {127'd0, m_valid});
                chk("cyc_a", a, m_a);
                chk("cyc_b", b, m_b);
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one element and hold it until taken (bounded wait).
    task automatic send(input logic [7:0] d);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) begin
            errors++;
            checks++;
            $display("FAIL send_timeout: got in_ready=0 expected 1 within 100 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        errors = 0; checks = 0;
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b0;
        idle(2);
        chk("rst_in_ready", {127'd0, in_ready}, 128'd0);
        chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_a", a, 128'd0);
        rst = 1'b0;
        idle(1);
        chk("post_rst_in_ready", {127'd0, in_ready}, 128'd1);

        // basic load
        for (int i = 0; i < 12; i++) begin
            if (i == 11) chk("basic_ov_before", {127'd0, out_valid}, 128'd0);
            send(basic_seq[i]);
        end
        chk("basic_ov", {127'd0, out_valid}, 128'd1);
        chk("basic_a", a, 128'h010201020102);
        chk("basic_b", b, 128'h010101010101);
        chk("model_a_pin", m_a, 128'h010201020102);
        idle(3);
        chk("basic_a_hold", a, 128'h010201020102);

        // backpressure: second pair 3..14 goes pending
        for (int i = 0; i < 12; i++) send(8'(3 + i));
        chk("bp_in_ready", {127'd0, in_ready}, 128'd0);
        chk("bp_a_hold", a, 128'h010201020102);
        idle(2);
        chk("bp_in_ready2", {127'd0, in_ready}, 128'd0);
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
        chk("bp_a_new", a, 128'h030405060708);
        chk("bp_b_new", b, 128'h090a0b0c0d0e);
        chk("bp_ov", {127'd0, out_valid}, 128'd1);
        chk("bp_in_ready_exit", {127'd0, in_ready}, 128'd1);

        // simultaneous drain and completion
        for (int i = 0; i < 12; i++) begin
            if (i == 11) out_ready = 1'b1;
            send(8'($urandom));
        end
        out_ready = 1'b0;
        chk("sim_in_ready", {127'd0, in_ready}, 128'd1);
        chk("sim_ov", {127'd0, out_valid}, 128'd1);

        // drain, then basic pattern with idle gaps
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
        chk("drain_ov", {127'd0, out_valid}, 128'd0);
        for (int i = 0; i < 12; i++) begin
            idle($urandom_range(0, 3));
            send(basic_seq[i]);
        end
        chk("gap_a", a, 128'h010201020102);
        chk("gap_b", b, 128'h010101010101);
        chk("gap_ov", {127'd0, out_valid}, 128'd1);

        // clr after four A elements, with valid data in the clr cycle
        for (int i = 0; i < 4; i++) send(8'($urandom));
        in_valid = 1'b1;
        in_data  = 8'hff;
        clr      = 1'b1;
        idle(1);
        clr      = 1'b0;
        in_valid = 1'b0;
        chk("clr_a_hold", a, 128'h010201020102);
        chk("clr_ov_hold", {127'd0, out_valid}, 128'd1);
        for (int i = 0; i < 12; i++) send(8'($urandom));
        chk("clr_pend_rdy", {127'd0, in_ready}, 128'd0);
        chk("clr_a_hold2", a, 128'h010201020102);

        // reset while pending
        rst = 1'b1;
        #1;
        chk("rstp_in_ready", {127'd0, in_ready}, 128'd0);
        idle(1);
        chk("rstp_ov", {127'd0, out_valid}, 128'd0);
        chk("rstp_a", a, 128'd0);
        chk("rstp_b", b, 128'd0);
        rst = 1'b0;
        idle(1);
        chk("rstp_in_ready_after", {127'd0, in_ready}, 128'd1);
        for (int i = 0; i < 12; i++) send(8'($urandom));
        chk("rstp_fresh_ov", {127'd0, out_valid}, 128'd1);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 2) == 0);
            clr       = ($urandom_range(0, 99) == 0);
            rst       = ($urandom_range(0, 299) == 0);
            idle(1);
        end
        in_valid = 1'b0; out_ready = 1'b0; clr = 1'b0; rst = 1'b0;
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/matrix_operand_loader.md
# matrix_operand_loader

Upstream stage of the matrix multiplier. Accepts a byte-serial stream of matrix elements over a valid/ready handshake, packs matrix A then matrix B into the multiplier's flat 128-bit operand buses, and presents the pair with a valid/ready handshake. Double-buffered: assembly of the next pair overlaps with the multiplier holding the current one.

## Interface
- aRow, default 3: rows of A
- aCol, default 2: columns of A; must equal bRow
- bRow, default 2: rows of B
- bCol, default 3: columns of B
- elemW, default 8: element width in bits
- busW, default 128: operand bus width
- matrixALen, default 48: aRow*aCol*elemW; must be ≤ busW
- matrixBLen, default 48: bRow*bCol*elemW; must be ≤ busW
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- clr  in  1  synchronous abort of the partial assembly; output slot unaffected
- in_data  in  elemW  next element, row-major; all of A, then all of B
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts in_data this cycle
- a  out  busW  packed A operand
- b  out  busW  packed B operand
- out_valid  out  1  a/b hold a complete pair
- out_ready  in  1  downstream consumes the pair this cycle

## Operation
- Accept: an element is taken on any rising edge with in_valid && in_ready && !rst && !clr.
- Packing: the assembly shift register is matrixALen (or matrixBLen) bits wide; shift left by elemW and insert in_data at the LSB. The first element therefore ends in bits [matrixALen-1 : matrixALen-elemW]. Bits above matrixALen/matrixBLen on a/b are always 0.
- Counter idx: counts accepted elements 0..NA-1 (NA = aRow*aCol), then 0..NB-1 (NB = bRow*bCol); wraps to 0 at each phase end.
- FSM:
  - FILL_A: accept A elements; on the NA-th accept, go to FILL_B.
  - FILL_B: accept B elements. On the NB-th accept, if the slot is free (out_valid==0 or out_ready==1 that cycle), copy assembly to a/b, set out_valid, and go to FILL_A. Otherwise go to PEND.
  - PEND: in_ready=0. When the slot is free, copy, set out_valid, and go to FILL_A.
- in_ready = !rst && (state != PEND). This path is combinational from state.
- Output slot: out_valid clears on out_ready unless a copy occurs the same cycle, in which case it stays 1 with the new data. a/b change only on a copy and hold while out_valid && !out_ready.
- clr: state becomes FILL_A, idx becomes 0, and the assembly registers are zeroed. An element presented in the clr cycle is dropped. a/b and out_valid are unaffected. clr in PEND discards the pending pair.
- rst has priority over clr. While rst is high, in_ready=0 and out_valid=0.

## Timing
- Reset values: state FILL_A, idx 0, assembly 0, a 0, b 0, out_valid 0, in_ready 0 while rst is high and 1 on the first cycle after.
- Minimum pair fill: NA+NB cycles at one element per cycle (12 with defaults). There are no bubbles between the A and B phases or between pairs.
- Latency: out_valid rises on the edge that accepts the last B element (slot free), so it is visible in the following cycle.
- PEND exit: out_ready sampled high in PEND makes out_valid stay 1 with the new data on the next edge, and in_ready is 1 in the next cycle.
- Throughput: with out_ready held high, one pair per NA+NB cycles and no PEND entry.
- Reset mid-operation: partial assembly and output slot are lost. The stream restarts with an A element.

## Test plan
- Basic load, defaults: stream 1,2,1,2,1,2 then six 1s with in_valid held high, out_ready=0. Expect a = 48'h010201020102 zero-extended and b = 48'h010101010101 zero-extended. out_valid goes high the cycle after the 12th accept, and a/b stay stable while held.
- Backpressure: keep out_ready=0 and stream a second pair 3..14. Expect in_ready=0 the cycle after its 12th accept (PEND) and a/b still holding the first pair. Pulse out_ready: the next cycle shows a = 48'h030405060708, out_valid=1, in_ready=1.
- Simultaneous drain/complete: assert out_ready in the same cycle as the last B accept. Expect no PEND cycle, out_valid to remain 1, and a/b to switch to the new pair on that edge.
- in_valid gaps: insert random idle cycles between elements. Expect packing identical to the basic load and idx to advance only on accepts.
- clr mid-load: assert clr after 4 A elements, with valid data present that cycle. Expect that element dropped and the next 12 accepts forming a correct pair. An existing output slot is unchanged throughout.
- Reset mid-PEND: assert rst for one cycle. Expect out_valid=0, a=b=0, and in_ready=0 during rst then 1 after. A fresh 12-element stream yields a correct pair.
